// File: rtl/stpu_mem_arbiter_pkg.sv
// Shared types and constants for the STPU memory arbiter.
// Holds the arbiter state encoding, the reset level and the default limits.
package stpu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUS_I = 2'd1,
    ARB_BUS_D = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  localparam logic       RST_ENABLE     = 1'b1;
  localparam int         DEF_STARVE_LIM = 4;
  localparam int         DEF_MAX_WAIT   = 15;
  localparam logic [3:0] SEL_ALL        = 4'hF;

  // Saturating increment used for the fetch-starvation counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] value, input logic [3:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage

// File: rtl/stpu_mem_arbiter.sv
// Single-port memory bus arbiter between the STPU fetch (I) and load/store (D) ports.
// D has priority; fetch starvation is bounded and a silent slave is aborted after MAX_WAIT cycles.
module stpu_mem_arbiter
  import stpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = DEF_STARVE_LIM,
  parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_sel,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_sel,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              stall_i,
  output logic              stall_d
);

  localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIM);
  localparam logic [7:0] MAX_WAIT_C   = 8'(MAX_WAIT);

  arb_state_e state;
  logic [3:0] starve_cnt;
  logic [7:0] wait_cnt;
  logic       d_wins;

  // D wins unless a pending fetch has already been passed over STARVE_LIM times.
  assign d_wins  = d_req && (!i_req || (starve_cnt < STARVE_LIM_C));

  assign stall_i = i_req & ~i_ack;
  assign stall_d = d_req & ~d_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state      <= ARB_IDLE;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_sel      <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_err      <= 1'b0;
      d_err      <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      i_err <= 1'b0;
      d_err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          wait_cnt <= '0;
          if (d_wins) begin
            state      <= ARB_BUS_D;
            m_req      <= 1'b1;
            m_we       <= d_we;
            m_sel      <= d_sel;
            m_addr     <= d_addr;
            m_wdata    <= d_wdata;
            starve_cnt <= i_req ? sat_inc4(starve_cnt, STARVE_LIM_C) : 4'd0;
          end else if (i_req) begin
            state      <= ARB_BUS_I;
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_sel      <= SEL_ALL;
            m_addr     <= i_addr;
            starve_cnt <= 4'd0;
          end else begin
            starve_cnt <= 4'd0;
          end
        end
        ARB_BUS_I, ARB_BUS_D: begin
          if (m_ack) begin
            state <= ARB_RESP;
            m_req <= 1'b0;
            if (state == ARB_BUS_I) begin
              i_rdata <= m_rdata;
              i_ack   <= 1'b1;
            end else begin
              d_rdata <= m_rdata;
              d_ack   <= 1'b1;
            end
          end else if (wait_cnt == MAX_WAIT_C - 8'd1) begin
            // Slave has been silent for MAX_WAIT bus cycles: abandon the transfer.
            state <= ARB_RESP;
            m_req <= 1'b0;
            if (state == ARB_BUS_I) i_err <= 1'b1;
            else                    d_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ARB_RESP: begin
          m_req <= 1'b0;
          state <= ARB_IDLE;
        end
        default: begin
          m_req <= 1'b0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
